// File: rtl/led_pkg.sv
// Shared types and default widths for the LED count engine.
package led_pkg;

    // Pattern update modes, encoded to match the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_UP      = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_RING    = 2'b10,
        MODE_JOHNSON = 2'b11
    } cnt_mode_t;

    localparam int DEF_DIV_WIDTH = 32;
    localparam int DEF_TAP_WIDTH = 5;
    localparam int DEF_OUT_WIDTH = 10;

endpackage

// File: rtl/led_count_engine_tick_gen.sv
// Free-running divider with a selectable power-of-two tap.
// hit is the combinational "divider at end of period" flag used by the
// pattern register; tick is its registered copy.
import led_pkg::*;

module tick_gen #(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH,
    parameter int TAP_WIDTH = DEF_TAP_WIDTH
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [TAP_WIDTH-1:0] tap_sel,
    input  logic                 load,
    output logic                 hit,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] div;
    logic [DIV_WIDTH-1:0] tap_mask;

    // Ones in bits [te:0]. Bits only exist up to DIV_WIDTH-1, so any tap
    // index beyond the top bit naturally saturates to a full mask (clamp,
    // never wrap).
    always_comb begin
        tap_mask = '0;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            tap_mask[i] = (i <= int'(tap_sel));
        end
    end

    // End of period: all selected low bits of the divider are ones.
    always_comb begin
        hit = enable && ((div & tap_mask) == tap_mask);
    end

    // Divider advance/clear and registered tick.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= hit;
            if (load) begin
                div <= '0;
            end else if (enable) begin
                div <= div + DIV_ONE;
            end
        end
    end

endmodule

// File: rtl/led_count_engine.sv
// LED pattern engine: a divider tick advances a pattern register in
// up, down, ring or Johnson mode. All outputs are registered.
import led_pkg::*;

module led_count_engine #(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH,
    parameter int TAP_WIDTH = DEF_TAP_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [TAP_WIDTH-1:0] tap_sel,
    input  logic [1:0]           mode,
    input  logic                 load,
    input  logic [OUT_WIDTH-1:0] load_value,
    output logic                 tick,
    output logic [OUT_WIDTH-1:0] count
);

    localparam logic [OUT_WIDTH-1:0] OUT_ONE = {{(OUT_WIDTH-1){1'b0}}, 1'b1};

    logic                 hit;
    cnt_mode_t            mode_sel;
    logic [OUT_WIDTH-1:0] count_next;

    tick_gen #(
        .DIV_WIDTH (DIV_WIDTH),
        .TAP_WIDTH (TAP_WIDTH)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .enable   (enable),
        .tap_sel  (tap_sel),
        .load     (load),
        .hit      (hit),
        .tick     (tick)
    );

    assign mode_sel = cnt_mode_t'(mode);

    // Next pattern for a hit in the selected mode.
    always_comb begin
        count_next = count;
        case (mode_sel)
            MODE_UP:      count_next = count + OUT_ONE;
            MODE_DOWN:    count_next = count - OUT_ONE;
            MODE_RING: begin
                // An all-zero ring would never light anything; seed bit 0.
                if (count == '0) begin
                    count_next = OUT_ONE;
                end else begin
                    count_next = {count[OUT_WIDTH-2:0], count[OUT_WIDTH-1]};
                end
            end
            MODE_JOHNSON: count_next = {count[OUT_WIDTH-2:0], ~count[OUT_WIDTH-1]};
            default:      count_next = count;
        endcase
    end

    // Pattern register: reset, then load, then hit.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (hit) begin
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_led_count_engine.sv
// Directed bench for led_count_engine (DIV_WIDTH=8 so tap clamping is visible).
module tb_led_count_engine;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       enable;
    logic [4:0] tap_sel;
    logic [1:0] mode;
    logic       load;
    logic [9:0] load_value;
    logic       tick;
    logic [9:0] count;

    int errors = 0;
    int checks = 0;

    led_count_engine #(
        .DIV_WIDTH (8),
        .TAP_WIDTH (5),
        .OUT_WIDTH (10)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .enable     (enable),
        .tap_sel    (tap_sel),
        .mode       (mode),
        .load       (load),
        .load_value (load_value),
        .tick       (tick),
        .count      (count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    logic [9:0] johnson_tbl [20];

    initial begin
        johnson_tbl = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F,
                        10'h03F, 10'h07F, 10'h0FF, 10'h1FF, 10'h3FF,
                        10'h3FE, 10'h3FC, 10'h3F8, 10'h3F0, 10'h3E0,
                        10'h3C0, 10'h380, 10'h300, 10'h200, 10'h000};

        reset = 1'b1; enable = 1'b0; tap_sel = 5'd0; mode = 2'b00;
        load = 1'b0; load_value = 10'h000;
        step(2);
        check("reset_tick", tick, 0);
        check("reset_count", count, 0);

        // Up mode, tap 2: period 8, first tick at cycle 8.
        reset = 1'b0; enable = 1'b1; tap_sel = 5'd2; mode = 2'b00;
        step(7);
        check("up_pre_tick", tick, 0);
        step(1);
        check("up_tick1", tick, 1);
        check("up_count1", count, 1);
        step(1);
        check("up_tick_one_cycle", tick, 0);
        check("up_count_hold", count, 1);
        step(7);
        check("up_tick2", tick, 1);
        check("up_count2", count, 2);
        step(8);
        check("up_count3", count, 3);

        // Down mode wraps from zero, tap 0: period 2.
        do_reset();
        tap_sel = 5'd0; mode = 2'b01;
        step(2);
        check("down_tick1", tick, 1);
        check("down_wrap", count, 10'h3FF);
        step(1);
        check("down_gap", tick, 0);
        step(1);
        check("down_second", count, 10'h3FE);

        // Ring self-start and rotation.
        do_reset();
        tap_sel = 5'd0; mode = 2'b10;
        step(2);
        check("ring_self_start", count, 10'h001);
        step(2);
        check("ring_second", count, 10'h002);
        step(16);
        check("ring_tick10", count, 10'h200);
        step(2);
        check("ring_wrap", count, 10'h001);
        load = 1'b1; load_value = 10'h200;
        step(1);
        load = 1'b0;
        check("ring_load", count, 10'h200);
        step(2);
        check("ring_msb_to_lsb", count, 10'h001);

        // Johnson from zero: 20-state cycle.
        do_reset();
        tap_sel = 5'd0; mode = 2'b11;
        for (int i = 0; i < 20; i++) begin
            step(2);
            check($sformatf("johnson_%0d", i), count, int'(johnson_tbl[i]));
        end

        // Tap clamp: tap 31 on an 8-bit divider behaves as tap 7 (period 256).
        do_reset();
        tap_sel = 5'd31; mode = 2'b00;
        step(255);
        check("clamp_pre_tick", tick, 0);
        step(1);
        check("clamp_tick", tick, 1);
        check("clamp_count", count, 1);
        step(100);
        enable = 1'b0;
        step(50);
        check("pause_no_tick", tick, 0);
        check("pause_count_hold", count, 1);
        enable = 1'b1;
        step(155);
        check("pause_delayed_pre", tick, 0);
        step(1);
        check("pause_delayed_tick", tick, 1);
        check("pause_delayed_count", count, 2);

        // Load coinciding with a hit: tick still pulses, count takes the load.
        do_reset();
        tap_sel = 5'd2; mode = 2'b00;
        step(7);
        load = 1'b1; load_value = 10'h155;
        step(1);
        load = 1'b0;
        check("load_hit_tick", tick, 1);
        check("load_hit_count", count, 10'h155);
        step(7);
        check("load_period_pre", tick, 0);
        step(1);
        check("load_period_tick", tick, 1);
        check("load_period_count", count, 10'h156);

        // Load with enable low still writes the pattern.
        enable = 1'b0; load = 1'b1; load_value = 10'h0AA;
        step(1);
        load = 1'b0;
        check("load_disabled", count, 10'h0AA);

        // Reset mid-run.
        enable = 1'b1;
        step(3);
        reset = 1'b1;
        step(1);
        check("midrun_reset_count", count, 0);
        check("midrun_reset_tick", tick, 0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_count_engine.md
Name: led_count_engine

Overview:
- Parametrised successor to the board-level free-running clock divider: one divider yields a one-cycle tick at a selectable power-of-two rate.
- Each tick advances an LED pattern register in one of four modes: up, down, ring, or Johnson.
- Sits between the CLOCK_50 domain and the LEDR outputs of the board top.
- Replaces hard-coded divider taps and constant LED patterns.

Parameters:
- DIV_WIDTH, 32, width of the free-running divider counter.
- TAP_WIDTH, 5, width of tap_sel; must satisfy 2^TAP_WIDTH >= DIV_WIDTH.
- OUT_WIDTH, 10, width of the pattern register (matches LEDR).

Ports:
- CLOCK_50, input, 1, system 50 MHz clock; the block's only clock.
- reset, input, 1, synchronous, active-high reset.
- enable, input, 1, when high, the divider advances and ticks are allowed.
- tap_sel, input, TAP_WIDTH, divider tap index t; tick period is 2^(t+1) enabled cycles.
- mode, input, 2, 00 = up, 01 = down, 10 = ring, 11 = Johnson.
- load, input, 1, synchronous load strobe.
- load_value, input, OUT_WIDTH, value written to count on load.
- tick, output, 1, registered one-cycle pulse per divider period.
- count, output, OUT_WIDTH, pattern register; drives LEDR.

Behaviour:
- Reset (sampled at posedge CLOCK_50, reset=1): div=0, tick=0, count=0. Reset overrides all other inputs.
- Effective tap te = min(tap_sel, DIV_WIDTH-1). Out-of-range values clamp; they never wrap.
- Tick condition: hit = enable && (div[te:0] == all ones).
- Each edge, when enable=1: div <= div+1, wrapping mod 2^DIV_WIDTH. When enable=0: div holds.
- tick <= hit. Tick is high for exactly one cycle per 2^(te+1) enabled cycles.
- First tick after reset is high in enabled cycle 2^(te+1), counting the first post-reset edge as cycle 1.
- Count updates on the same edge that sets tick=1. Count and tick therefore change together, with zero extra latency.
- Count next-state on a hit:
  - up: count+1; wraps all-ones to 0.
  - down: count-1; wraps 0 to all-ones.
  - ring: rotate left by 1 (MSB moves to LSB). If count==0, load 1 instead (self-start).
  - Johnson: {count[OUT_WIDTH-2:0], ~count[OUT_WIDTH-1]}. Period is 2*OUT_WIDTH ticks from 0.
- Load priority (highest first): reset, load, hit.
  - load=1: count <= load_value and div <= 0. The next tick arrives a full period later.
  - If load and hit coincide, load wins. tick still pulses that cycle, but count takes load_value.
  - load works regardless of enable.
- mode and tap_sel are sampled every cycle; changes take effect on the next hit.
  - Changing tap_sel mid-period can shorten that period.
  - A non-one-hot value in ring mode simply rotates; no correction except the all-zero case.
- enable falling mid-period: div freezes and the count holds. The period resumes from the frozen value when enable rises.
- No combinational path from any input to any output.

Decomposition:
- Package led_pkg holds:
  - typedef enum logic [1:0] cnt_mode_t {MODE_UP, MODE_DOWN, MODE_RING, MODE_JOHNSON};
  - the default width constants.
- Sub-module tick_gen (DIV_WIDTH, TAP_WIDTH):
  - contains the divider, tap clamp, registered tick, and divider clear on load;
  - outputs hit and tick.
- led_count_engine instantiates tick_gen and implements the pattern register and mode mux.

Test Plan:
- Reset, then enable=1, tap_sel=2, mode=up: tick pulses every 8 cycles, first at cycle 8; count reads 1, 2, 3 after 24 cycles.
- Down-mode wrap from reset, tap_sel=0: first tick gives count=0x3FF, second gives 0x3FE.
- Ring, tap_sel=0, count=0: ticks give 0x001, 0x002, then after 10 ticks 0x001 again. load_value=0x200 plus one tick gives 0x001.
- Johnson from 0, tap_sel=0: sequence 0x001, 0x003, …, 0x3FF, 0x3FE, …, 0x000, returning to 0 after 20 ticks.
- tap_sel=31 with DIV_WIDTH=8: behaves exactly as tap_sel=7, period 256. Drop enable for 50 cycles mid-period: the next tick is delayed by exactly 50 cycles.
- load asserted on a hit cycle with load_value=0x155: tick=1 and count=0x155; the next tick is 2^(te+1) cycles later. Assert reset mid-run: next edge gives count=0 and tick=0.
